// File: rtl/prime_pkg.sv
// Shared definitions for the prime sieve stream block.
// Holds the default size constants and the controller state encoding.
package prime_pkg;

    localparam int unsigned DefaultLimit = 999999;
    localparam int unsigned DefaultAw    = 20;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StScan,
        StMark,
        StEmit,
        StFinish
    } state_e;

endpackage

// File: rtl/sieve_flag_ram.sv
// One-bit simple dual-port flag memory for the sieve.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data (1 = composite)
//   raddr - read address
//   rdata - read data, valid one cycle after raddr is presented
// Contents are not reset; the controller clears the used range before each run.
module sieve_flag_ram #(
    parameter int unsigned Depth = 1000000,
    parameter int unsigned AW    = 20
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wdata,
    input  logic [AW-1:0] raddr,
    output logic          rdata
);

    logic mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/prime_sieve_stream.sv
// Sieve of Eratosthenes that streams the primes 2..lim over a valid/ready port.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   start        - begin a run (honoured only when idle)
//   limit_i      - run limit, clamped to LIMIT and latched on start
//   busy, done   - run in progress / one-cycle completion pulse
//   prime_o      - current prime, qualified by prime_valid
//   prime_valid  - beat present
//   prime_ready  - consumer accepts the beat
//   count_o      - primes accepted in the current or last run (saturating)
module prime_sieve_stream
    import prime_pkg::*;
#(
    parameter int unsigned LIMIT = DefaultLimit,
    parameter int unsigned AW    = DefaultAw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] limit_i,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] prime_o,
    output logic          prime_valid,
    input  logic          prime_ready,
    output logic [AW-1:0] count_o
);

    localparam logic [AW-1:0] LimitW = AW'(LIMIT);

    state_e state_q, state_d;

    logic [AW-1:0] lim_q, lim_d;
    logic [AW-1:0] i_q, i_d;
    logic [AW:0]   j_q, j_d;     // one extra bit so j + i never wraps
    logic [AW:0]   k_q, k_d;     // clear address, then emit candidate (may reach lim + 1)
    logic [AW-1:0] prime_q, prime_d;
    logic [AW-1:0] count_q, count_d;
    logic          pend_q, pend_d;   // a flag read was issued last cycle
    logic          valid_q, valid_d;

    logic          we, wdata, rdata;
    logic [AW-1:0] waddr, raddr;

    logic [2*AW-1:0] sq;
    logic [AW:0]     lim_ext, j_step;
    logic            sq_gt, clear_last, emit_done, mark_done;

    assign sq         = {{AW{1'b0}}, i_q} * {{AW{1'b0}}, i_q};
    assign sq_gt      = sq > {{AW{1'b0}}, lim_q};
    assign lim_ext    = {1'b0, lim_q};
    assign j_step     = j_q + {1'b0, i_q};
    assign clear_last = (k_q == lim_ext);
    assign emit_done  = (k_q > lim_ext);
    assign mark_done  = (j_step > lim_ext);

    sieve_flag_ram #(
        .Depth (LIMIT + 1),
        .AW    (AW)
    ) u_flags (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StClear;
            StClear:  if (clear_last) state_d = (lim_q < AW'(2)) ? StFinish : StScan;
            StScan: begin
                if (!pend_q && sq_gt) state_d = StEmit;
                else if (pend_q && !rdata) state_d = StMark;
            end
            StMark:   if (mark_done) state_d = StScan;
            StEmit:   if (!valid_q && !pend_q && emit_done) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs and memory port control
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        we    = 1'b0;
        wdata = 1'b0;
        waddr = k_q[AW-1:0];
        raddr = i_q;
        unique case (state_q)
            StClear: begin
                busy = 1'b1;
                we   = 1'b1;
            end
            StScan:  busy = 1'b1;
            StMark: begin
                busy  = 1'b1;
                we    = 1'b1;
                wdata = 1'b1;
                waddr = j_q[AW-1:0];
            end
            StEmit: begin
                busy  = 1'b1;
                raddr = k_q[AW-1:0];
            end
            StFinish: done = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lim_q   <= '0;
            i_q     <= AW'(2);
            j_q     <= '0;
            k_q     <= '0;
            prime_q <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            lim_q   <= lim_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            prime_q <= prime_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
        end
    end

    // Datapath next-state
    always_comb begin
        lim_d   = lim_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        prime_d = prime_q;
        count_d = count_q;
        pend_d  = pend_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    lim_d   = (limit_i > LimitW) ? LimitW : limit_i;
                    count_d = '0;
                    k_d     = '0;
                    i_d     = AW'(2);
                    pend_d  = 1'b0;
                    valid_d = 1'b0;
                end
            end
            StClear: begin
                k_d = k_q + (AW+1)'(1);
                if (clear_last) begin
                    i_d    = AW'(2);
                    pend_d = 1'b0;
                end
            end
            StScan: begin
                if (!pend_q) begin
                    if (sq_gt) k_d = (AW+1)'(2);
                    else pend_d = 1'b1;
                end else begin
                    pend_d = 1'b0;
                    // sq <= lim here, so the narrowing keeps every bit
                    if (!rdata) j_d = sq[AW:0];
                    else i_d = i_q + AW'(1);
                end
            end
            StMark: begin
                if (mark_done) i_d = i_q + AW'(1);
                else j_d = j_step;
            end
            StEmit: begin
                if (valid_q) begin
                    if (prime_ready) begin
                        valid_d = 1'b0;
                        k_d     = k_q + (AW+1)'(1);
                        if (count_q != '1) count_d = count_q + AW'(1);
                    end
                end else if (!pend_q) begin
                    if (!emit_done) pend_d = 1'b1;
                end else begin
                    pend_d = 1'b0;
                    if (!rdata) begin
                        valid_d = 1'b1;
                        prime_d = k_q[AW-1:0];
                    end else begin
                        k_d = k_q + (AW+1)'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign prime_o     = prime_q;
    assign prime_valid = valid_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_prime_sieve_stream.sv
module tb_prime_sieve_stream;
    import prime_pkg::*;

    localparam int unsigned LIMIT = 1000;
    localparam int unsigned AW    = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] limit_i;
    logic          busy;
    logic          done;
    logic [AW-1:0] prime_o;
    logic          prime_valid;
    logic          prime_ready;
    logic [AW-1:0] count_o;

    int compared   = 0;
    int mismatched = 0;
    int last_beat;

    always #5 clk = ~clk;

    prime_sieve_stream #(
        .LIMIT (LIMIT),
        .AW    (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .limit_i     (limit_i),
        .busy        (busy),
        .done        (done),
        .prime_o     (prime_o),
        .prime_valid (prime_valid),
        .prime_ready (prime_ready),
        .count_o     (count_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: primes up to n by trial division
    function automatic void primes_upto(input int n, output int q[$]);
        bit is_p;
        q = {};
        for (int c = 2; c <= n; c++) begin
            is_p = 1'b1;
            for (int d = 2; d * d <= c; d++) begin
                if (c % d == 0) is_p = 1'b0;
            end
            if (is_p) q.push_back(c);
        end
    endfunction

    // One complete run; inputs driven and outputs sampled on the falling edge.
    task automatic run(input int lim, input bit rnd_ready, input bit poke_start,
                       input string tag, output int last);
        int            exp_q[$];
        int            idx;
        int            eff;
        bit            seen_done;
        bit            stalled;
        logic [AW-1:0] held;
        idx       = 0;
        seen_done = 1'b0;
        stalled   = 1'b0;
        held      = '0;
        last      = -1;
        eff       = (lim > int'(LIMIT)) ? int'(LIMIT) : lim;
        primes_upto(eff, exp_q);
        @(negedge clk);
        limit_i = AW'(lim);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy_after_start"}, busy, 1);
        for (int cyc = 0; cyc < 40000; cyc++) begin
            if (poke_start && cyc == 3) begin
                start   = 1'b1;
                limit_i = AW'(7);
            end else begin
                start = 1'b0;
            end
            if (stalled) begin
                chk({tag, " stall_valid"}, prime_valid, 1);
                chk({tag, " stall_data"}, prime_o, held);
            end
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            prime_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            stalled     = prime_valid && !prime_ready;
            held        = prime_o;
            if (prime_valid && prime_ready) begin
                chk({tag, " beat"}, prime_o, (idx < exp_q.size()) ? exp_q[idx] : -1);
                last = int'(prime_o);
                idx++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, " done_seen"}, seen_done, 1);
        chk({tag, " beats"}, idx, exp_q.size());
        chk({tag, " count"}, count_o, exp_q.size());
        chk({tag, " busy_at_done"}, busy, 0);
        chk({tag, " valid_at_done"}, prime_valid, 0);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, done, 0);
        prime_ready = 1'b0;
    endtask

    initial begin
        int w;
        int rl;
        rst         = 1'b1;
        start       = 1'b0;
        limit_i     = '0;
        prime_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset valid", prime_valid, 0);
        chk("reset prime", prime_o, 0);
        chk("reset count", count_o, 0);
        rst = 1'b0;

        run(30, 1'b0, 1'b0, "lim30_ready", last_beat);
        chk("lim30_ready last", last_beat, 29);
        run(30, 1'b1, 1'b0, "lim30_random", last_beat);
        run(1, 1'b1, 1'b0, "lim1", last_beat);
        run(2, 1'b0, 1'b0, "lim2", last_beat);
        chk("lim2 last", last_beat, 2);
        run(100, 1'b1, 1'b0, "lim100", last_beat);
        run(20, 1'b1, 1'b0, "lim20_after100", last_beat);
        chk("lim20 last", last_beat, 19);
        run(30, 1'b1, 1'b1, "start_while_busy", last_beat);

        // Reset while marking composites
        @(negedge clk);
        limit_i = AW'(30);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (dut.state_q != StMark && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("reached mark", dut.state_q == StMark, 1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun rst busy", busy, 0);
        chk("midrun rst done", done, 0);
        chk("midrun rst valid", prime_valid, 0);
        chk("midrun rst prime", prime_o, 0);
        chk("midrun rst count", count_o, 0);
        @(negedge clk);
        rst = 1'b0;
        run(30, 1'b1, 1'b0, "after_rst", last_beat);
        chk("after_rst last", last_beat, 29);

        run(2000, 1'b1, 1'b0, "clamped", last_beat);
        chk("clamped last", last_beat, 997);
        chk("clamped count", count_o, 168);

        for (int r = 0; r < 2; r++) begin
            rl = int'($urandom_range(0, 150));
            run(rl, 1'b1, 1'b0, "random_lim", last_beat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/prime_sieve_stream.md
PRIME_SIEVE_STREAM -- requirements
Module: prime_sieve_stream

Interface
REQ-001 Parameter LIMIT, 999999, largest candidate the block supports; memory depth is LIMIT+1.
REQ-002 Parameter AW, 20, width of candidate, address and count values; SHALL satisfy 2**AW > LIMIT.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-006 limit_i  input  AW  run limit, latched on an accepted start.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse when a run completes.
REQ-009 prime_o  output  AW  current prime; stable while prime_valid is high and prime_ready is low.
REQ-010 prime_valid  output  1  prime_o holds a valid prime.
REQ-011 prime_ready  input  1  consumer accepts a beat when prime_valid and prime_ready are both high.
REQ-012 count_o  output  AW  number of primes accepted in the current or last run.

Function
REQ-013 FSM states SHALL be IDLE, CLEAR, SCAN, MARK, EMIT and FINISH.
REQ-014 IDLE + start: latch lim = min(limit_i, LIMIT), clear count_o, go to CLEAR; start outside IDLE SHALL be ignored.
REQ-015 CLEAR SHALL write 0 to flag addresses 0..lim, one per cycle, so a run never inherits marks from an earlier run.
REQ-016 If lim < 2, CLEAR SHALL go to FINISH with no beats emitted.
REQ-017 SCAN: with i starting at 2, while i*i <= lim, read flag(i) and wait the RAM read latency (1 cycle).
REQ-018 In SCAN, flag(i)=0 SHALL enter MARK with j = i*i; flag(i)=1 SHALL increment i.
REQ-019 SCAN SHALL go to EMIT with k = 2 once i*i > lim; compute i*i at 2*AW bits, never truncated.
REQ-020 MARK SHALL write 1 to flag(j) each cycle, with j += i computed at AW+1 bits, until j > lim; it then increments i and returns to SCAN.
REQ-021 EMIT: for k = 2..lim, read flag(k); flag 0 SHALL present k on prime_o with prime_valid high until accepted, then continue with k+1.
REQ-022 EMIT: flag 1 SHALL skip k with no beat; no beat is presented for k > lim.
REQ-023 count_o SHALL increment by 1 on each accepted beat and saturate at all-ones.
REQ-024 After k passes lim with no beat pending, go to FINISH.
REQ-025 FINISH SHALL pulse done for 1 cycle, drop busy in the same cycle and return to IDLE.
REQ-026 prime_valid SHALL deassert in the cycle after acceptance unless the next beat is ready; throughput is at most 1 beat per 2 cycles.
REQ-027 prime_ready with prime_valid low SHALL have no effect.

Reset
REQ-028 rst high SHALL force IDLE immediately and set busy=0, done=0, prime_valid=0, prime_o=0, count_o=0, i=2, j=0, k=0 and lim=0, including mid-run.
REQ-029 Flag memory contents are not reset; CLEAR (REQ-015) guarantees correctness after any reset.

Structure
REQ-030 Shared package prime_pkg SHALL hold the FSM state enum and the default LIMIT/AW constants.
REQ-031 One sub-module, sieve_flag_ram, SHALL implement the 1-bit simple dual-port memory (write port plus synchronous read port, latency 1, inferred, no vendor IP).
REQ-032 The top-level seven-segment, BCD and debounce logic stays outside this block; prime_o feeds it directly.

Verification
REQ-033 LIMIT=1000, start with limit_i=30, ready held high -> beats 2,3,5,7,11,13,17,19,23,29, then done, count_o=10.
REQ-034 limit_i=30, ready toggled randomly -> same sequence, prime_o stable while stalled, no duplicate or lost beats.
REQ-035 limit_i=1, then limit_i=2 -> first run: done with no beats, count_o=0; second run: single beat 2, count_o=1.
REQ-036 Run limit_i=100 (25 primes), then limit_i=20 -> second run emits 2..19 (8 primes) only, proving CLEAR works.
REQ-037 Cover two control cases: (a) start pulsed while busy is ignored; (b) rst asserted during MARK -> all outputs return to reset values next edge, and a fresh run with limit_i=30 passes.
REQ-038 limit_i=2000 with LIMIT=1000 -> clamped to 1000, last beat 997, count_o=168.
